// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Per-button synchronizer, debouncer and edge detector. Each channel takes
//   a raw, bouncy pad input and produces a clean level plus single-cycle
//   press/release pulses. Channels are independent; they share only the
//   clock, the reset and the debounce period.
//
// Ports (top):
//   clock    in   system clock, rising edge
//   i_reset  in   asynchronous active-low reset
//   i_btn    in   [NB_BTN] raw pad inputs
//   o_btn    out  [NB_BTN] debounced level
//   o_rise   out  [NB_BTN] one-cycle pulse per accepted 0->1
//   o_fall   out  [NB_BTN] one-cycle pulse per accepted 1->0
//
// Parameters:
//   NB_BTN      channel count
//   NB_CNT      stability counter width
//   STABLE_CNT  synchronized cycles of a stable new level needed before it
//               is accepted; legal range 2 .. 2**NB_CNT-1
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// btn_debounce_ch
//   One channel: 2-flop synchronizer followed by a 4-state debounce FSM.
//
// Ports:
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset
//   btn_i   in   raw pad input
//   lvl_o   out  debounced level (registered)
//   rise_o  out  accepted-press pulse (registered)
//   fall_o  out  accepted-release pulse (registered)
// ---------------------------------------------------------------------------
module btn_debounce_ch #(
  parameter int NB_CNT     = 20,
  parameter int STABLE_CNT = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  localparam logic [NB_CNT-1:0] CNT_ZERO = '0;
  localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);
  // Last count value before a level is accepted; the counter never goes
  // past it, so it cannot wrap.
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(STABLE_CNT - 1);

  // Synchronizer: sync_q[0] may go metastable, only sync_q[1] is used.
  logic [1:0]        sync_q;
  logic              s2;

  logic [1:0]        state_q, state_d;
  logic [NB_CNT-1:0] cnt_q,   cnt_d;
  logic              lvl_q,   lvl_d;
  logic              rise_q,  rise_d;
  logic              fall_q,  fall_d;

  assign s2 = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        lvl_d = 1'b0;
        if (s2) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end

      WAIT_HIGH: begin
        if (!s2) begin
          // Bounce: drop the attempt entirely, no partial credit kept.
          state_d = IDLE_LOW;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          lvl_d   = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      IDLE_HIGH: begin
        lvl_d = 1'b1;
        if (!s2) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end

      WAIT_LOW: begin
        if (s2) begin
          state_d = IDLE_HIGH;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          lvl_d   = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE_LOW;
        cnt_d   = CNT_ZERO;
        lvl_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE_LOW;
      cnt_q   <= CNT_ZERO;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

module btn_debounce #(
  parameter int NB_BTN     = 4,
  parameter int NB_CNT     = 20,
  parameter int STABLE_CNT = 1000000
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [NB_BTN-1:0] o_btn,
  output logic [NB_BTN-1:0] o_rise,
  output logic [NB_BTN-1:0] o_fall
);

  genvar g;
  generate
    for (g = 0; g < NB_BTN; g++) begin : g_ch
      btn_debounce_ch #(
        .NB_CNT    (NB_CNT),
        .STABLE_CNT(STABLE_CNT)
      ) u_ch (
        .clk_i (clock),
        .rst_ni(i_reset),
        .btn_i (i_btn[g]),
        .lvl_o (o_btn[g]),
        .rise_o(o_rise[g]),
        .fall_o(o_fall[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with STABLE_CNT=8, NB_CNT=4. Inputs are
// driven 1 time unit after a rising edge, so the next rising edge is the
// first sampling edge ("edge 1"); an accepted change shows at edge 10.
module tb_btn_debounce;

  localparam int NB = 4;

  logic          clock;
  logic          i_reset;
  logic [NB-1:0] i_btn;
  logic [NB-1:0] o_btn, o_rise, o_fall;

  int n_chk  = 0;
  int n_fail = 0;

  btn_debounce #(.NB_BTN(NB), .NB_CNT(4), .STABLE_CNT(8)) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .i_btn  (i_btn),
    .o_btn  (o_btn),
    .o_rise (o_rise),
    .o_fall (o_fall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    i_btn   = '0;
    i_reset = 1'b0;
    step(2);
    i_reset = 1'b1;
    step(1);
  endtask

  // Pulse monitor used by the random phase.
  logic    mon_en = 1'b0;
  int      rise_cnt [NB];
  int      fall_cnt [NB];
  int      viol = 0;
  logic [NB-1:0] prev_rise = '0, prev_fall = '0;

  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      for (int c = 0; c < NB; c++) begin
        if (o_rise[c]) rise_cnt[c]++;
        if (o_fall[c]) fall_cnt[c]++;
        if (o_rise[c] && prev_rise[c]) viol++;
        if (o_fall[c] && prev_fall[c]) viol++;
        if (o_rise[c] && o_fall[c])    viol++;
      end
      prev_rise = o_rise;
      prev_fall = o_fall;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] seen;
    logic [NB-1:0] cur, nxt;
    int exp_rise [NB];
    int exp_fall [NB];

    for (int c = 0; c < NB; c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; exp_rise[c] = 0; exp_fall[c] = 0;
    end

    i_reset = 1'b0;
    i_btn   = 4'hF;
    @(posedge clock); #1;

    // Reset held with all buttons pressed.
    step(3);
    chk("rst_btn",  o_btn,  4'h0);
    chk("rst_rise", o_rise, 4'h0);
    chk("rst_fall", o_fall, 4'h0);

    // Buttons held through reset release: normal press latency.
    i_reset = 1'b1;
    step(9);
    chk("hold_e9_rise",  o_rise, 4'h0);
    chk("hold_e9_btn",   o_btn,  4'h0);
    step(1);
    chk("hold_e10_rise", o_rise, 4'hF);
    chk("hold_e10_btn",  o_btn,  4'hF);
    step(1);
    chk("hold_e11_rise", o_rise, 4'h0);

    // Clean press then release on channel 0.
    do_reset();
    i_btn = 4'b0001;
    step(9);
    chk("press_e9_rise",  o_rise, 4'h0);
    chk("press_e9_btn",   o_btn,  4'h0);
    step(1);
    chk("press_e10_rise", o_rise, 4'b0001);
    chk("press_e10_btn",  o_btn,  4'b0001);
    step(1);
    chk("press_e11_rise", o_rise, 4'h0);
    chk("press_e11_btn",  o_btn,  4'b0001);
    step(9);
    i_btn = 4'b0000;
    step(9);
    chk("rel_e9_fall",  o_fall, 4'h0);
    chk("rel_e9_btn",   o_btn,  4'b0001);
    step(1);
    chk("rel_e10_fall", o_fall, 4'b0001);
    chk("rel_e10_btn",  o_btn,  4'h0);
    step(1);
    chk("rel_e11_fall", o_fall, 4'h0);

    // Bounce rejection on channel 1.
    do_reset();
    seen = '0;
    i_btn[1] = 1'b1; for (int k = 0; k < 5; k++) begin step(1); seen |= o_rise | o_btn; end
    i_btn[1] = 1'b0; for (int k = 0; k < 2; k++) begin step(1); seen |= o_rise | o_btn; end
    i_btn[1] = 1'b1; for (int k = 0; k < 5; k++) begin step(1); seen |= o_rise | o_btn; end
    i_btn[1] = 1'b0; for (int k = 0; k < 12; k++) begin step(1); seen |= o_rise | o_btn; end
    chk("bounce_none", seen, 4'h0);
    begin
      int np = 0;
      i_btn[1] = 1'b1;
      for (int k = 0; k < 15; k++) begin step(1); if (o_rise[1]) np++; end
      chk("bounce_one_rise", np, 1);
      chk("bounce_btn", o_btn, 4'b0010);
    end

    // Simultaneous channels.
    do_reset();
    i_btn = 4'b1010;
    step(9);
    chk("simul_e9_rise",  o_rise, 4'h0);
    step(1);
    chk("simul_e10_rise", o_rise, 4'b1010);
    chk("simul_e10_btn",  o_btn,  4'b1010);
    step(1);
    chk("simul_e11_rise", o_rise, 4'h0);
    chk("simul_e11_btn",  o_btn,  4'b1010);

    // Reset in the middle of a wait on channel 3.
    do_reset();
    seen = '0;
    i_btn = 4'b1000;
    for (int k = 0; k < 8; k++) begin step(1); seen |= o_rise | o_btn; end
    i_reset = 1'b0;
    step(1);
    seen |= o_rise | o_btn;
    step(1);
    seen |= o_rise | o_btn;
    chk("midrst_nopulse", seen, 4'h0);
    i_reset = 1'b1;
    seen = '0;
    for (int k = 0; k < 9; k++) begin step(1); seen |= o_rise; end
    chk("midrst_e1_9", seen, 4'h0);
    step(1);
    chk("midrst_e10_rise", o_rise, 4'b1000);
    chk("midrst_e10_btn",  o_btn,  4'b1000);

    // Random accepted transitions: every level is held long enough.
    do_reset();
    mon_en = 1'b1;
    cur = '0;
    for (int it = 0; it < 50; it++) begin
      nxt = cur ^ NB'($urandom_range(1, 15));
      for (int c = 0; c < NB; c++) begin
        if (nxt[c] && !cur[c]) exp_rise[c]++;
        if (!nxt[c] && cur[c]) exp_fall[c]++;
      end
      cur   = nxt;
      i_btn = cur;
      step($urandom_range(12, 18));
    end
    step(12);
    mon_en = 1'b0;
    for (int c = 0; c < NB; c++) begin
      chk($sformatf("rand_rise_cnt%0d", c), rise_cnt[c], exp_rise[c]);
      chk($sformatf("rand_fall_cnt%0d", c), fall_cnt[c], exp_fall[c]);
    end
    chk("rand_pulse_width", viol, 0);
    chk("rand_final_btn", o_btn, cur);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
